// File: rtl/incrementer_8b_pkg.sv
`default_nettype none
// ============================================================================
// incrementer_8b_pkg : shared constants for the registered +1 incrementer
// Revision: 1.0
// ============================================================================
package incrementer_8b_pkg;

  localparam int INC_DEFAULT_WIDTH = 8;

  // Operand that wraps to zero and raises carry-out
  localparam logic [INC_DEFAULT_WIDTH-1:0] INC_ALL_ONES = '1;

endpackage : incrementer_8b_pkg
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// half_adder : one-bit half adder, a single stage of the increment ripple chain
// Revision: 1.0
// ============================================================================
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : half_adder
`default_nettype wire

// File: rtl/incrementer_8b.sv
`default_nettype none
// ============================================================================
// incrementer_8b : registered s = a + 1 with carry-out and sticky overflow flag
// Revision: 1.0
// ============================================================================
module incrementer_8b
  import incrementer_8b_pkg::*;
#(
  parameter int WIDTH = INC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic             ovf_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf_sticky
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  assign w_c[0] = 1'b1;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      half_adder u_ha (
        .a     (a[i]),
        .b     (w_c[i]),
        .sum   (w_sum[i]),
        .carry (w_c[i+1])
      );
    end
  endgenerate

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  // Operand is only looked at when qualified, so X on an idle bus cannot leak
  always_comb begin
    valid_d = in_valid;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      s_d    = w_sum;
      cout_d = w_c[WIDTH];
    end
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (in_valid && w_c[WIDTH]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid  = valid_q;
  assign s          = s_q;
  assign cout       = cout_q;
  assign ovf_sticky = ovf_q;

endmodule : incrementer_8b
`default_nettype wire

// File: tb/tb_incrementer_8b.sv
`default_nettype none
// ============================================================================
// tb_incrementer_8b : scoreboard bench for incrementer_8b
// Revision: 1.0
// ============================================================================
module tb_incrementer_8b;
  import incrementer_8b_pkg::*;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic       ovf_clr;
  logic       out_valid;
  logic [7:0] s;
  logic       cout;
  logic       ovf_sticky;

  exp_t       sb_q[$];
  int         errors;
  int         checks;

  incrementer_8b #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .ovf_clr    (ovf_clr),
    .out_valid  (out_valid),
    .s          (s),
    .cout       (cout),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got s=%0h with empty scoreboard at %0t", s, $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_s", {24'd0, s}, {24'd0, e.s});
          chk("sb_cout", {31'd0, cout}, {31'd0, e.cout});
          chk("sb_ovf", {31'd0, ovf_sticky}, {31'd0, e.ovf});
        end
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic clr,
                       input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    in_valid = 1'b1;
    a        = op;
    ovf_clr  = clr;
    e.s      = es;
    e.cout   = ec;
    e.ovf    = eo;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic clr);
    in_valid = 1'b0;
    a        = 'x;
    ovf_clr  = clr;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ones;
    errors   = 0;
    checks   = 0;
    ones     = INC_ALL_ONES;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'h55;
    ovf_clr  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_s", {24'd0, s}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_sticky}, 32'd0);
    rst_n = 1'b1;

    issue(8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
    issue(8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    issue(8'h0F, 1'b0, 8'h10, 1'b0, 1'b0);
    issue(8'h7F, 1'b0, 8'h80, 1'b0, 1'b0);
    issue(ones,  1'b0, 8'h00, 1'b1, 1'b1);
    issue(8'h02, 1'b0, 8'h03, 1'b0, 1'b1);
    idle(1'b1);
    chk("clr_ovf", {31'd0, ovf_sticky}, 32'd0);
    issue(ones,  1'b1, 8'h00, 1'b1, 1'b1);

    issue(8'h10, 1'b0, 8'h11, 1'b0, 1'b1);
    issue(8'h20, 1'b0, 8'h21, 1'b0, 1'b1);
    issue(8'h30, 1'b0, 8'h31, 1'b0, 1'b1);
    idle(1'b0);
    chk("gate_out_valid", {31'd0, out_valid}, 32'd0);
    chk("gate_s_hold", {24'd0, s}, 32'h31);
    idle(1'b0);
    chk("gate_s_hold2", {24'd0, s}, 32'h31);
    chk("gate_cout_hold", {31'd0, cout}, 32'd0);

    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'h40;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_s", {24'd0, s}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf_sticky}, 32'd0);
    rst_n = 1'b1;
    idle(1'b0);

    for (int i = 0; i < 256; i++) begin
      issue(8'(i), 1'b0, 8'(i + 1), (i == 255), (i == 255));
    end
    idle(1'b0);
    idle(1'b0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_incrementer_8b
`default_nettype wire

// File: doc/incrementer_8b.md
Name: incrementer_8b

Overview:
- Registered unsigned +1 incrementer: on each accepted sample, outputs S = A + 1 with carry-out, one clock later.
- Default width is 8 bits. Built as a ripple chain of half-adders (carry-in tied to 1).
- Used as a counter/address-bump primitive in datapaths that need a registered result and an overflow indication.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on the clk rising edge.
- in_valid  input  1  qualifies a; when 1, the operand is captured this cycle.
- a  input  WIDTH  unsigned operand.
- out_valid  output  1  high for one cycle per accepted operand, exactly one cycle after capture.
- s  output  WIDTH  registered result, equal to (a + 1) mod 2^WIDTH.
- cout  output  1  registered carry-out; 1 only when a was all ones.
- ovf_sticky  output  1  set when any accepted operand produces cout=1; held until cleared.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset: when rst_n=0 at a rising edge, the next state is out_valid=0, s=0, cout=0, ovf_sticky=0. Reset overrides all other inputs.
- Arithmetic is combinational: sum[i] = a[i] XOR c[i]; c[i+1] = a[i] AND c[i]; c[0] = 1; cout = c[WIDTH].
- Equivalent check: {cout, s} = a + 1, computed at WIDTH+1 bits.
- Latency is 1 cycle. On a rising edge with rst_n=1 and in_valid=1: s and cout take the combinational result, and out_valid becomes 1.
- On a rising edge with rst_n=1 and in_valid=0: out_valid becomes 0, and s and cout hold their previous values.
- Throughput is one operand per cycle. There is no backpressure and no ready signal.
- Wrap-around: a = all ones gives s = 0 and cout = 1. Every other a gives cout = 0.
- ovf_sticky update rule:
  - Sets on the edge that registers cout=1 with in_valid=1.
  - ovf_clr=1 clears it.
  - If a set and a clear occur on the same edge, set wins and ovf_sticky=1.
- Reset mid-stream: a sample presented on the reset edge is discarded; out_valid=0 on the following cycle.
- Unknown inputs: X on a while in_valid=0 must not affect any output.

Decomposition:
- Shared package holds:
  - INC_DEFAULT_WIDTH = 8.
  - A localparam for the all-ones operand, used by the bench for the overflow case.
- One natural sub-module, half_adder (inputs a, b; outputs sum, carry). It is instantiated WIDTH times in a generate loop to form the ripple chain.
- Top level contains:
  - The chain.
  - The output registers (s, cout, out_valid).
  - The sticky overflow flag.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=8'h55 -> out_valid=0, s=8'h00, cout=0, ovf_sticky=0.
- Basic: a=8'h00, in_valid=1 -> next cycle s=8'h01, cout=0, out_valid=1. Then a=8'h01 -> s=8'h02, cout=0.
- Carry ripple: a=8'h0F -> s=8'h10, cout=0. Also a=8'h7F -> s=8'h80, cout=0.
- Overflow: a=8'hFF -> s=8'h00, cout=1, out_valid=1, ovf_sticky=1 from that cycle on.
  - Next, a=8'h02 -> cout=0, ovf_sticky stays 1.
  - Then pulse ovf_clr -> ovf_sticky=0.
  - Then ovf_clr=1 together with a=8'hFF, in_valid=1 -> ovf_sticky=1 (set wins).
- Valid gating: back-to-back operands 8'h10, 8'h20, 8'h30, then in_valid=0 -> out_valid=1 for exactly 3 cycles with s=8'h11, 8'h21, 8'h31; afterwards s holds 8'h31 and out_valid=0.
- Reset mid-stream: in_valid=1, a=8'h40 on the same edge as rst_n=0 -> next cycle out_valid=0, s=8'h00. Exhaustive sweep of a over 0..255 matches (a+1) mod 256, with cout=1 only at 255.
